// File: rtl/bpu_gshare.sv
// -----------------------------------------------------------------------------
// bpu_gshare -- gshare branch predictor for the MIPS fetch stage.
//
// A pattern history table of 2-bit saturating counters is indexed by
// pc[IDX_W+1:2] XOR the global history. A tagged, valid-qualified BTB
// indexed by pc[IDX_W+1:2] supplies the target and gates every taken
// prediction. The global history is updated speculatively on fetch and
// restored from the carried snapshot on a mispredict. After reset a
// sweep of 2^IDX_W cycles initialises the tables.
//
// Ports
//   clk, rst              clock (rising edge), async active-high reset
//   pc_in                 fetch PC, looked up combinationally
//   fetch_valid_in        fetch accepted; may shift the speculative GHR
//   pred_taken_out        predict taken (BTB hit and counter msb set)
//   pred_target_out       predicted target, 0 when not taken
//   pred_ghr_out          GHR value used for this prediction
//   init_busy_out         init sweep in progress
//   update_en_in          resolved branch from EX is valid
//   update_pc_in          resolved branch PC
//   update_taken_in       actual direction
//   update_target_in      actual target
//   update_ghr_in         GHR snapshot carried with the branch
//   update_mispredict_in  restore the GHR from the snapshot
// -----------------------------------------------------------------------------
module bpu_gshare #(
    parameter int PC_W   = 32,
    parameter int IDX_W  = 10,
    parameter int HIST_W = 8,
    parameter int TAG_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   pc_in,
    input  logic              fetch_valid_in,
    output logic              pred_taken_out,
    output logic [PC_W-1:0]   pred_target_out,
    output logic [HIST_W-1:0] pred_ghr_out,
    output logic              init_busy_out,
    input  logic              update_en_in,
    input  logic [PC_W-1:0]   update_pc_in,
    input  logic              update_taken_in,
    input  logic [PC_W-1:0]   update_target_in,
    input  logic [HIST_W-1:0] update_ghr_in,
    input  logic              update_mispredict_in
);

    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    init_cnt_q, init_cnt_d;
    logic [HIST_W-1:0]   ghr_q, ghr_d;

    // Tables: no reset, the init sweep is their only initialisation.
    logic [1:0]          pht_q        [DEPTH];
    logic [DEPTH-1:0]    btb_valid_q;
    logic [TAG_W-1:0]    btb_tag_q    [DEPTH];
    logic [PC_W-1:0]     btb_target_q [DEPTH];

    // ---------------- lookup ----------------
    logic [IDX_W-1:0]    bidx, pidx;
    logic [TAG_W-1:0]    ftag;
    logic                hit, raw_taken, run;

    assign run       = (state_q == ST_RUN);
    assign bidx      = pc_in[IDX_W+1:2];
    assign pidx      = bidx ^ IDX_W'(ghr_q);
    assign ftag      = pc_in[IDX_W+TAG_W+1:IDX_W+2];
    assign hit       = btb_valid_q[bidx] && (btb_tag_q[bidx] == ftag);
    assign raw_taken = hit && pht_q[pidx][1];

    // ---------------- update side ----------------
    logic [IDX_W-1:0]    ubidx, uidx;
    logic [TAG_W-1:0]    utag;
    logic [1:0]          ucnt, ucnt_next;
    logic                upd, recover;

    assign ubidx   = update_pc_in[IDX_W+1:2];
    assign uidx    = ubidx ^ IDX_W'(update_ghr_in);
    assign utag    = update_pc_in[IDX_W+TAG_W+1:IDX_W+2];
    assign ucnt    = pht_q[uidx];
    assign upd     = run && update_en_in;
    assign recover = upd && update_mispredict_in;

    always_comb begin
        ucnt_next = ucnt;
        if (update_taken_in) begin
            if (ucnt != 2'b11) ucnt_next = ucnt + 2'b01;
        end else begin
            if (ucnt != 2'b00) ucnt_next = ucnt - 2'b01;
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            ghr_q      <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            ghr_q      <= ghr_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        ghr_d      = ghr_q;
        case (state_q)
            ST_INIT: begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == IDX_W'(DEPTH - 1)) state_d = ST_RUN;
            end
            ST_RUN: begin
                // Recovery wins over a same-cycle speculative shift.
                if (recover)
                    ghr_d = {update_ghr_in[HIST_W-2:0], update_taken_in};
                else if (fetch_valid_in && hit)
                    ghr_d = {ghr_q[HIST_W-2:0], raw_taken};
            end
            default: state_d = ST_INIT;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        init_busy_out   = !run;
        pred_taken_out  = run && raw_taken;
        pred_target_out = pred_taken_out ? btb_target_q[bidx] : '0;
        pred_ghr_out    = run ? ghr_q : '0;
    end

    // ---------------- table writes ----------------
    // Reads above see the pre-edge contents; there is deliberately no bypass.
    always_ff @(posedge clk) begin
        if (!run) begin
            pht_q[init_cnt_q]       <= 2'b01;
            btb_valid_q[init_cnt_q] <= 1'b0;
        end else if (upd) begin
            pht_q[uidx] <= ucnt_next;
            if (update_taken_in) begin
                btb_valid_q[ubidx]  <= 1'b1;
                btb_tag_q[ubidx]    <= utag;
                btb_target_q[ubidx] <= update_target_in;
            end
        end
    end

    // Byte-offset and bits above the tag never take part in indexing.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_in, update_pc_in};

endmodule
